i2c_switch_pca9545: RTL and testbench
=====================================

Name: i2c_switch_pca9545

Overview:
Synthesizable model of a PCA9545A-style 4-channel I2C bus switch. It acts as a target on the shared I2C bus and is oversampled by the system clock. Its control register selects which downstream channels are enabled. Two instances sit on the QSFP management bus (addresses 0xE0 and 0xE4) and gate the sideband IO expanders and the module I2C paths of four QSFP cages.

Parameters:
DEVICE_ID, 8'hE0, 8-bit write address; bits [7:1] are the 7-bit target address and bit 0 is ignored.
SYNC_STAGES, 2, number of synchronizer flops on scl_i and sda_i (minimum 2).

Ports:
sys_clk  in  1  system clock; the only clock; oversamples SCL/SDA (at least 8x SCL).
sys_resetn  in  1  synchronous, active-low reset.
scl_i  in  1  I2C SCL, asynchronous.
sda_i  in  1  I2C SDA, asynchronous.
sda_oe  out  1  1 = pull SDA low (open drain); top level drives 0 when set, else Z.
int_n_i  in  4  active-low interrupt inputs of channels 3..0.
gpio_o  out  8  channel enables; [3:0] = effective control register, [7:4] = 0.

Behaviour:
- Reset (sync, active-low): on the next sys_clk edge, state = IDLE, control and pending registers = 0, sda_oe = 0, gpio_o = 0. Applies mid-transaction; SDA is released that cycle.
- Input conditioning: scl_i and sda_i each pass through SYNC_STAGES flops, plus one history flop for edge detection.
- Bus events:
  - START (incl. repeated START): synced SDA falls while synced SCL is high. Recognized in every state; goes to ADDR, bit count 0, sda_oe = 0.
  - STOP: synced SDA rises while synced SCL is high. Goes to IDLE and releases SDA.
  - A rising SCL edge samples a bit. A falling SCL edge changes sda_oe. sda_oe updates within 1 sys_clk of the detected SCL fall.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- ADDR: shift in 8 bits MSB first on SCL rises.
  - After the 8th bit, compare byte[7:1] with DEVICE_ID[7:1].
  - Match: go to ADDR_ACK.
  - Mismatch: go to IGNORE (sda_oe stays 0 until START/STOP).
- ADDR_ACK: assert sda_oe on the next SCL fall; hold it through the 9th clock; on the following SCL fall, branch on the R/W bit.
  - R/W = 0: release SDA and go to WRITE.
  - R/W = 1: go to READ and drive the first data bit on that same fall.
- WRITE: shift in 8 bits. After the 8th bit:
  - pending[3:0] = byte[3:0]; byte[7:4] is discarded.
  - ACK exactly as in ADDR_ACK, then return to WRITE for further bytes.
  - Last byte wins. Every data byte is ACKed.
- Control register update: control = pending on STOP only, and only if at least one data byte was written in that transaction. gpio_o changes only then; a repeated START does not commit.
- READ:
  - Read byte = {~int_n_i, control[3:0]}, captured at the ACK-to-READ transition.
  - On each SCL fall, sda_oe = ~bit, MSB first.
  - After the 8th bit, release SDA on the next fall and go to READ_ACK.
- READ_ACK: sample SDA on the SCL rise.
  - 0 (ACK): recapture the read byte and continue in READ.
  - 1 (NACK): go to IGNORE, SDA released.
- IGNORE: passive; waits for START or STOP.
- SCL stretching: never.
- General call (address 0x00): not supported; treated as a mismatch.

Test Plan:
- DEVICE_ID=8'hE0. Write 0xE0, 0x05, STOP -> sda_oe ACKs both bytes (9th clock); gpio_o = 0x00 until STOP, then 0x05.
- DEVICE_ID=8'hE0. Write address 0xE4, 0x0F -> no ACK (SDA high on 9th clock), sda_oe never asserted, gpio_o unchanged.
- After control = 0x05, int_n_i = 4'b1101, read 0xE1, master NACK, STOP -> byte 0x25 on SDA, SDA released after the NACK.
- Write 0xE0, 0x01, 0xF3, STOP -> both data bytes ACKed, gpio_o = 0x03 (last byte, upper nibble dropped).
- Write 0xE0, 0x0A, repeated START, 0xE1, read with master ACK, then NACK -> both bytes read back the old control value; gpio_o unchanged (no STOP in between, so no commit).
- Assert sys_resetn = 0 during read data bit 3 while sda_oe = 1 -> sda_oe = 0 and gpio_o = 0 on the next sys_clk; the next transaction after release works normally.

Source files
------------

// File: rtl/i2c_switch_pca9545.sv
// ---------------------------------------------------------------------------
// i2c_switch_pca9545
//
// PCA9545A-style 4-channel I2C bus switch, implemented as an I2C target that
// oversamples SCL/SDA with the system clock. A write transfer loads a pending
// channel mask. That mask becomes the control register (and so drives the
// channel enables) only on a STOP that closes a transfer carrying at least one
// data byte. A read transfer returns {~int_n_i, control}.
//
// Ports
//   sys_clk     in   system clock; must run at least 8x the SCL rate
//   sys_resetn  in   synchronous active-low reset
//   scl_i       in   I2C SCL (asynchronous)
//   sda_i       in   I2C SDA (asynchronous)
//   sda_oe      out  1 = pull SDA low (open drain, registered)
//   int_n_i     in   active-low interrupt inputs of channels 3..0
//   gpio_o      out  channel enables: [3:0] = control register, [7:4] = 0
//
// Handshake: there is no valid/ready interface. The only timing contract is
// the I2C one: data is sampled on a detected SCL rise, and sda_oe changes
// only on the sys_clk edge where an SCL fall is detected (or on START, STOP
// and reset, which all release SDA). SCL is never stretched.
// ---------------------------------------------------------------------------
module i2c_switch_pca9545 #(
  parameter logic [7:0] DEVICE_ID   = 8'hE0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_resetn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [3:0] int_n_i,
  output logic [7:0] gpio_o
);

  // Fewer than two synchronizer flops is never safe; clamp silently.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    IGNORE
  } state_t;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic [SS-1:0] scl_sync;
  logic [SS-1:0] sda_sync;
  logic          scl_d;
  logic          sda_d;
  logic          scl_s;
  logic          sda_s;

  // Synchronizers reset to the idle-bus level (both lines high) so that
  // leaving reset never manufactures a START.
  always_ff @(posedge sys_clk) begin
    if (!sys_resetn) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SS-2:0], scl_i};
      sda_sync <= {sda_sync[SS-2:0], sda_i};
      scl_d    <= scl_sync[SS-1];
      sda_d    <= sda_sync[SS-1];
    end
  end

  assign scl_s = scl_sync[SS-1];
  assign sda_s = sda_sync[SS-1];

  // -------------------------------------------------------------------------
  // Bus events. START/STOP require SCL high on both the current and the
  // previous sample so an SDA change coinciding with an SCL edge is treated
  // as data, not as a bus condition.
  // -------------------------------------------------------------------------
  logic start_evt;
  logic stop_evt;
  logic scl_rise;
  logic scl_fall;

  assign start_evt = scl_s && scl_d &&  sda_d && !sda_s;
  assign stop_evt  = scl_s && scl_d && !sda_d &&  sda_s;
  assign scl_rise  =  scl_s && !scl_d;
  assign scl_fall  = !scl_s &&  scl_d;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  state_t     state;
  logic [3:0] bit_cnt;   // ADDR/WRITE: bits received; READ: bits driven
  logic [7:0] shreg;     // receive shift register
  logic [7:0] rd_sh;     // transmit shift register, MSB goes out next
  logic       rw;        // R/W bit of the matched address byte
  logic       ack_on;    // ACK cycles: 1 once sda_oe has been asserted
  logic       wrote;     // a data byte landed in pending since last START
  logic [3:0] pending;
  logic [3:0] control;

  logic [7:0] rx_byte;   // byte completed by the current SCL rise
  logic       addr_match;
  logic [7:0] rd_now;    // fresh read value

  assign rx_byte = {shreg[6:0], sda_s};

  // General call (7-bit address 0) is never claimed, even if DEVICE_ID
  // were misconfigured to zero.
  assign addr_match = (rx_byte[7:1] == DEVICE_ID[7:1]) && (rx_byte[7:1] != 7'd0);

  assign rd_now = {~int_n_i, control};

  assign gpio_o = {4'b0000, control};

  // -------------------------------------------------------------------------
  // Protocol FSM. START and STOP override every state; otherwise the state
  // reacts only to SCL rises (sampling) and SCL falls (driving).
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!sys_resetn) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'h00;
      rd_sh   <= 8'h00;
      rw      <= 1'b0;
      ack_on  <= 1'b0;
      wrote   <= 1'b0;
      pending <= 4'h0;
      control <= 4'h0;
      sda_oe  <= 1'b0;
    end else if (start_evt) begin
      // Also covers repeated START: no commit, any partial write is dropped.
      state   <= ADDR;
      bit_cnt <= 4'd0;
      ack_on  <= 1'b0;
      wrote   <= 1'b0;
      sda_oe  <= 1'b0;
    end else if (stop_evt) begin
      state  <= IDLE;
      ack_on <= 1'b0;
      sda_oe <= 1'b0;
      if (wrote) begin
        control <= pending;
      end
      wrote <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sda_oe <= 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            shreg <= rx_byte;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              rw      <= sda_s;
              ack_on  <= 1'b0;
              state   <= addr_match ? ADDR_ACK : IGNORE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        ADDR_ACK: begin
          // First fall: pull SDA for the 9th clock. Second fall: leave the
          // ACK slot and, for a read, put the MSB on the bus at once.
          if (scl_fall) begin
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              ack_on <= 1'b0;
              if (rw) begin
                state   <= READ;
                sda_oe  <= ~rd_now[7];
                rd_sh   <= {rd_now[6:0], 1'b0};
                bit_cnt <= 4'd1;
              end else begin
                state   <= WRITE;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
              end
            end
          end
        end

        WRITE: begin
          if (scl_rise) begin
            shreg <= rx_byte;
            if (bit_cnt == 4'd7) begin
              // Only the channel nibble is kept; the last byte wins.
              pending <= rx_byte[3:0];
              wrote   <= 1'b1;
              bit_cnt <= 4'd0;
              ack_on  <= 1'b0;
              state   <= WRITE_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        WRITE_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              ack_on  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= WRITE;
            end
          end
        end

        READ: begin
          // bit_cnt == 8 means all eight bits have been on the bus for a
          // full clock; this fall opens the controller's ACK slot.
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= READ_ACK;
            end else begin
              sda_oe  <= ~rd_sh[7];
              rd_sh   <= {rd_sh[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              // ACK: reload so the next fall starts a fresh byte.
              rd_sh   <= rd_now;
              bit_cnt <= 4'd0;
              state   <= READ;
            end else begin
              state <= IGNORE;
            end
          end
        end

        IGNORE: begin
          sda_oe <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          sda_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_switch_pca9545.sv
// ---------------------------------------------------------------------------
// tb_i2c_switch_pca9545
//
// Directed bench for i2c_switch_pca9545 (DEVICE_ID = 8'hE0). A bit-banged
// I2C controller drives SCL and an open-drain SDA (bus = controller & ~sda_oe).
// Each SCL phase lasts Q system clocks, so SCL runs at 1/(4Q) of sys_clk.
// Inputs change and outputs are sampled on the falling edge of sys_clk.
// ---------------------------------------------------------------------------
module tb_i2c_switch_pca9545;

  localparam int Q = 8;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic       sys_clk = 1'b0;
  logic       sys_resetn = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [3:0] int_n = 4'hF;
  logic [7:0] gpio;

  always #5 sys_clk = ~sys_clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_switch_pca9545 #(
    .DEVICE_ID  (8'hE0),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_resetn(sys_resetn),
    .scl_i     (scl),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .int_n_i   (int_n),
    .gpio_o    (gpio)
  );

  // Counts every cycle the target pulls SDA.
  int oe_cnt = 0;
  always @(posedge sys_clk) if (sda_oe) oe_cnt++;

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Works from idle (SCL high) and as a repeated START (SCL low).
  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl   = 1'b1; wait_clk(2 * Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    b     = sda_bus;
    wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  // ack = SDA level seen by the controller on the 9th clock (0 = ACK).
  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  // Watchdog: the sequence is time-driven, so this only trips on a bench bug.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    logic       ack;
    logic       b;
    logic [7:0] d;
    int         oe_before;

    // Reset
    wait_clk(4);
    check("reset_sda_oe", {7'd0, sda_oe}, 8'h00);
    check("reset_gpio", gpio, 8'h00);
    sys_resetn = 1'b1;
    wait_clk(4);

    // 1: write 0x05, commit on STOP
    i2c_start();
    write_byte(8'hE0, ack); check("w05_addr_ack", {7'd0, ack}, 8'h00);
    write_byte(8'h05, ack); check("w05_data_ack", {7'd0, ack}, 8'h00);
    check("w05_sda_released", {7'd0, sda_oe}, 8'h00);
    check("w05_gpio_before_stop", gpio, 8'h00);
    i2c_stop();
    check("w05_gpio_after_stop", gpio, 8'h05);

    // 2: foreign address, never ACKed
    oe_before = oe_cnt;
    i2c_start();
    write_byte(8'hE4, ack); check("e4_addr_nack", {7'd0, ack}, 8'h01);
    write_byte(8'h0F, ack); check("e4_data_nack", {7'd0, ack}, 8'h01);
    i2c_stop();
    check("e4_oe_never", (oe_cnt == oe_before) ? 8'h01 : 8'h00, 8'h01);
    check("e4_gpio_unchanged", gpio, 8'h05);

    // 3: read with int_n = 1101 -> {0010, 0101} = 0x25, controller NACKs
    int_n = 4'b1101;
    i2c_start();
    write_byte(8'hE1, ack); check("rd_addr_ack", {7'd0, ack}, 8'h00);
    read_byte(1'b1, d);     check("rd_byte", d, 8'h25);
    check("rd_released_after_nack", {7'd0, sda_oe}, 8'h00);
    i2c_stop();
    check("rd_gpio", gpio, 8'h05);

    // 4: two data bytes, last wins, upper nibble dropped
    i2c_start();
    write_byte(8'hE0, ack); check("w2_addr_ack", {7'd0, ack}, 8'h00);
    write_byte(8'h01, ack); check("w2_d0_ack", {7'd0, ack}, 8'h00);
    write_byte(8'hF3, ack); check("w2_d1_ack", {7'd0, ack}, 8'h00);
    i2c_stop();
    check("w2_gpio", gpio, 8'h03);

    // 5: write 0x0A, repeated START, read twice -> old control {0010,0011}
    i2c_start();
    write_byte(8'hE0, ack); check("rs_addr_ack", {7'd0, ack}, 8'h00);
    write_byte(8'h0A, ack); check("rs_data_ack", {7'd0, ack}, 8'h00);
    i2c_start();
    write_byte(8'hE1, ack); check("rs_raddr_ack", {7'd0, ack}, 8'h00);
    read_byte(1'b0, d);     check("rs_byte0", d, 8'h23);
    read_byte(1'b1, d);     check("rs_byte1", d, 8'h23);
    check("rs_gpio_no_commit", gpio, 8'h03);
    i2c_stop();

    // 6: set control = 0x02 so read bit 3 is 0 (target pulls SDA)
    int_n = 4'hF;
    i2c_start();
    write_byte(8'hE0, ack); check("pre_addr_ack", {7'd0, ack}, 8'h00);
    write_byte(8'h02, ack); check("pre_data_ack", {7'd0, ack}, 8'h00);
    i2c_stop();
    check("pre_gpio", gpio, 8'h02);

    // Read 0x02: clock bits 7..4, bit 3 then sits on the bus
    i2c_start();
    write_byte(8'hE1, ack); check("rst_addr_ack", {7'd0, ack}, 8'h00);
    for (int i = 0; i < 4; i++) read_bit(b);
    check("rst_bit3_driven", {7'd0, sda_oe}, 8'h01);
    sys_resetn = 1'b0;
    wait_clk(1);
    check("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
    check("rst_gpio", gpio, 8'h00);
    wait_clk(2);
    sys_resetn = 1'b1;
    wait_clk(2);
    i2c_stop();

    // Normal transaction after reset
    i2c_start();
    write_byte(8'hE0, ack); check("post_addr_ack", {7'd0, ack}, 8'h00);
    write_byte(8'h06, ack); check("post_data_ack", {7'd0, ack}, 8'h00);
    check("post_gpio_before_stop", gpio, 8'h00);
    i2c_stop();
    check("post_gpio", gpio, 8'h06);

    wait_clk(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
